// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one SRAM-style port between IFU (m0)
//            and LSU (m1), one transaction in flight, with response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_req,
    input  logic [ADDR_W-1:0]     i_m0_addr,
    input  logic                  i_m0_wen,
    input  logic [DATA_W-1:0]     i_m0_wdata,
    input  logic [DATA_W/8-1:0]   i_m0_wstrb,
    output logic                  o_m0_gnt,
    output logic                  o_m0_rvalid,
    output logic [DATA_W-1:0]     o_m0_rdata,
    output logic                  o_m0_err,
    input  logic                  i_m1_req,
    input  logic [ADDR_W-1:0]     i_m1_addr,
    input  logic                  i_m1_wen,
    input  logic [DATA_W-1:0]     i_m1_wdata,
    input  logic [DATA_W/8-1:0]   i_m1_wstrb,
    output logic                  o_m1_gnt,
    output logic                  o_m1_rvalid,
    output logic [DATA_W-1:0]     o_m1_rdata,
    output logic                  o_m1_err,
    output logic                  o_s_req,
    output logic [ADDR_W-1:0]     o_s_addr,
    output logic                  o_s_wen,
    output logic [DATA_W-1:0]     o_s_wdata,
    output logic [DATA_W/8-1:0]   o_s_wstrb,
    input  logic                  i_s_gnt,
    input  logic                  i_s_rvalid,
    input  logic [DATA_W-1:0]     i_s_rdata
);

    // Counter only needs to reach TIMEOUT-1: expiry is detected on the increment.
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_pick;
    logic                  w_pick_owner;
    logic                  w_owner_next;
    logic                  w_done;
    logic                  w_done_err;
    logic                  w_expire;

    logic                  r_m0_gnt;
    logic                  r_m1_gnt;
    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic                  r_m0_err;
    logic                  r_m1_err;
    logic [DATA_W-1:0]     r_m0_rdata;
    logic [DATA_W-1:0]     r_m1_rdata;

    assign w_expire     = (TIMEOUT > 0) && (r_cnt == c_CNT_LAST);
    assign w_owner_next = w_pick ? w_pick_owner : r_owner;

    always_comb begin
        w_state_next = r_state;
        w_pick       = 1'b0;
        w_pick_owner = r_owner;
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_m0_req && i_m1_req) begin
                    w_pick       = 1'b1;
                    w_pick_owner = ~r_last_owner;
                end else if (i_m0_req) begin
                    w_pick       = 1'b1;
                    w_pick_owner = 1'b0;
                end else if (i_m1_req) begin
                    w_pick       = 1'b1;
                    w_pick_owner = 1'b1;
                end
                if (w_pick) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A real response always beats a coincident timeout.
                if (i_s_gnt && i_s_rvalid) begin
                    w_done = 1'b1;
                end else if (w_expire) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else if (i_s_gnt) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_s_rvalid) begin
                    w_done = 1'b1;
                end else if (w_expire) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_done) begin
            w_state_next = S_RESP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pick) begin
                r_owner      <= w_pick_owner;
                r_last_owner <= w_pick_owner;
                r_addr       <= w_pick_owner ? i_m1_addr  : i_m0_addr;
                r_wen        <= w_pick_owner ? i_m1_wen   : i_m0_wen;
                r_wdata      <= w_pick_owner ? i_m1_wdata : i_m0_wdata;
                r_wstrb      <= w_pick_owner ? i_m1_wstrb : i_m0_wstrb;
                r_cnt        <= '0;
            end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Master-side outputs are computed from next-state so they align with RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_gnt    <= (w_state_next != S_IDLE) && !w_owner_next;
            r_m1_gnt    <= (w_state_next != S_IDLE) &&  w_owner_next;
            r_m0_rvalid <= w_done && !r_owner;
            r_m1_rvalid <= w_done &&  r_owner;
            r_m0_err    <= w_done && w_done_err && !r_owner;
            r_m1_err    <= w_done && w_done_err &&  r_owner;
            if (w_done && !r_owner) begin
                r_m0_rdata <= w_done_err ? '0 : i_s_rdata;
            end
            if (w_done && r_owner) begin
                r_m1_rdata <= w_done_err ? '0 : i_s_rdata;
            end
        end
    end

    assign o_m0_gnt    = r_m0_gnt;
    assign o_m1_gnt    = r_m1_gnt;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_err    = r_m0_err;
    assign o_m1_err    = r_m1_err;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;

    assign o_s_req   = (r_state == S_ISSUE);
    assign o_s_addr  = r_addr;
    assign o_s_wen   = r_wen;
    assign o_s_wdata = r_wdata;
    assign o_s_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench: vector table, scoreboard of expected
//            responses, and directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW  = 32;
    localparam int c_DW  = 64;
    localparam int c_SW  = c_DW / 8;
    localparam int c_TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m1_req, m0_wen, m1_wen;
    logic [c_AW-1:0] m0_addr, m1_addr;
    logic [c_DW-1:0] m0_wdata, m1_wdata;
    logic [c_SW-1:0] m0_wstrb, m1_wstrb;
    logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [c_DW-1:0] m0_rdata, m1_rdata;
    logic            s_req, s_wen, s_gnt, s_rvalid;
    logic [c_AW-1:0] s_addr;
    logic [c_DW-1:0] s_wdata, s_rdata;
    logic [c_SW-1:0] s_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          owner;
        logic [63:0] rdata;
        bit          err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          m0;
        bit          m1;
        bit          wen;
        int          lat;
        logic [63:0] rdata;
        bit          exp_owner;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (c_AW),
        .DATA_W (c_DW),
        .TIMEOUT(c_TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m0_req   (m0_req),
        .i_m0_addr  (m0_addr),
        .i_m0_wen   (m0_wen),
        .i_m0_wdata (m0_wdata),
        .i_m0_wstrb (m0_wstrb),
        .o_m0_gnt   (m0_gnt),
        .o_m0_rvalid(m0_rvalid),
        .o_m0_rdata (m0_rdata),
        .o_m0_err   (m0_err),
        .i_m1_req   (m1_req),
        .i_m1_addr  (m1_addr),
        .i_m1_wen   (m1_wen),
        .i_m1_wdata (m1_wdata),
        .i_m1_wstrb (m1_wstrb),
        .o_m1_gnt   (m1_gnt),
        .o_m1_rvalid(m1_rvalid),
        .o_m1_rdata (m1_rdata),
        .o_m1_err   (m1_err),
        .o_s_req    (s_req),
        .o_s_addr   (s_addr),
        .o_s_wen    (s_wen),
        .o_s_wdata  (s_wdata),
        .o_s_wstrb  (s_wstrb),
        .i_s_gnt    (s_gnt),
        .i_s_rvalid (s_rvalid),
        .i_s_rdata  (s_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req, s_wen,
                 m0_rdata, m1_rdata, s_addr, s_wdata, s_wstrb};
    endfunction

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (m0_rvalid || m1_rvalid)) begin
            if (m0_rvalid && m1_rvalid) begin
                chk("sb_both_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'h1);
            end else if (sbq.size() == 0) begin
                chk("sb_unexpected_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'h0);
            end else begin
                e = sbq.pop_front();
                chk("sb_owner", 64'(m1_rvalid), 64'(e.owner));
                chk("sb_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.rdata);
                chk("sb_err", 64'(m1_rvalid ? m1_err : m0_err), 64'(e.err));
                chk("sb_other_err", 64'(m1_rvalid ? m0_err : m1_err), 64'h0);
            end
        end
    end

    task automatic wait_sreq(input string name, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!s_req && k < budget);
        if (!s_req) chk({name, "_sreq_timeout"}, 64'(s_req), 64'h1);
    endtask

    // Called on the ISSUE negedge: grant now, answer lat cycles later.
    task automatic slave_resp(input int lat, input logic [63:0] data, input bit owner);
        exp_t e;
        e.owner = owner;
        e.rdata = data;
        e.err   = 1'b0;
        s_gnt   = 1'b1;
        if (lat == 0) begin
            s_rvalid = 1'b1;
            s_rdata  = data;
            sbq.push_back(e);
        end else begin
            @(negedge clk);
            s_gnt = 1'b0;
            repeat (lat - 1) @(negedge clk);
            s_rvalid = 1'b1;
            s_rdata  = data;
            sbq.push_back(e);
        end
        @(negedge clk);
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        #1;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sbq.size() != 0) begin
            chk("drain_missing_rvalid", 64'(sbq.size()), 64'h0);
            sbq.delete();
        end
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 0, 64'h0000_0000_0000_00A0, 1};
        vecs[1] = '{1, 1, 1, 1, 64'h0000_0000_0000_00A1, 0};
        vecs[2] = '{1, 0, 0, 2, 64'h0123_4567_89AB_CDEF, 0};
        vecs[3] = '{1, 1, 0, 3, 64'hFFFF_0000_FFFF_0000, 1};
        vecs[4] = '{0, 1, 1, 0, 64'h0000_0000_0000_00A4, 1};
        vecs[5] = '{1, 1, 0, 1, 64'h5555_AAAA_5555_AAAA, 0};
        vecs[6] = '{0, 1, 0, 2, 64'h0000_0000_0000_00A6, 1};
        vecs[7] = '{1, 1, 1, 3, 64'h8000_0000_0000_0001, 0};

        rst = 1'b1;
        {m0_req, m1_req, m0_wen, m1_wen} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_wstrb = '0; m1_wstrb = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_sreq", 64'(s_req), 64'h0);

        // Minimum-latency read by m0
        m0_req  = 1'b1;
        m0_addr = 32'h8000_0000;
        @(negedge clk);
        chk("t1_sreq_cycle1", 64'(s_req), 64'h1);
        chk("t1_addr", 64'(s_addr), 64'h8000_0000);
        chk("t1_wen", 64'(s_wen), 64'h0);
        chk("t1_gnt", 64'({m1_gnt, m0_gnt}), 64'h1);
        m0_req = 1'b0;
        slave_resp(0, 64'hDEAD_BEEF_0000_0001, 1'b0);
        chk("t1_rvalid_cycle2", 64'(m0_rvalid), 64'h1);
        chk("t1_rdata", m0_rdata, 64'hDEAD_BEEF_0000_0001);
        chk("t1_m1_quiet", 64'({m1_gnt, m1_rvalid, m1_err, m1_rdata}), 64'h0);
        chk("t1_sreq_low", 64'(s_req), 64'h0);
        drain(4);

        // Vector table: request pattern, latency and expected owner
        for (int i = 0; i < 8; i++) begin
            m0_req   = vecs[i].m0;
            m1_req   = vecs[i].m1;
            m0_addr  = 32'h0000_0100 + 32'(i);
            m1_addr  = 32'h0000_0200 + 32'(i);
            m0_wen   = vecs[i].wen;
            m1_wen   = vecs[i].wen;
            m0_wdata = 64'h1000 + 64'(i);
            m1_wdata = 64'h2000 + 64'(i);
            wait_sreq($sformatf("vec%0d", i), 6);
            chk($sformatf("vec%0d_gnt", i), 64'({m1_gnt, m0_gnt}), vecs[i].exp_owner ? 64'h2 : 64'h1);
            chk($sformatf("vec%0d_addr", i), 64'(s_addr),
                vecs[i].exp_owner ? 64'h200 + 64'(i) : 64'h100 + 64'(i));
            chk($sformatf("vec%0d_wdata", i), s_wdata,
                vecs[i].exp_owner ? 64'h2000 + 64'(i) : 64'h1000 + 64'(i));
            chk($sformatf("vec%0d_wen", i), 64'(s_wen), 64'(vecs[i].wen));
            m0_req = 1'b0;
            m1_req = 1'b0;
            slave_resp(vecs[i].lat, vecs[i].rdata, vecs[i].exp_owner);
            drain(8);
        end

        // Continuous contention: grants alternate, starting with m1 (m0 won last)
        m0_addr = 32'h7000;
        m1_addr = 32'h7100;
        m0_wen  = 1'b0;
        m1_wen  = 1'b0;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bit own;
            own = (j % 2 == 0);
            wait_sreq($sformatf("rr%0d", j), 6);
            chk($sformatf("rr%0d_gnt", j), 64'({m1_gnt, m0_gnt}), own ? 64'h2 : 64'h1);
            chk($sformatf("rr%0d_addr", j), 64'(s_addr), own ? 64'h7100 : 64'h7000);
            if (j == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            slave_resp(2, 64'hC0DE_0000 + 64'(j), own);
        end
        drain(6);

        // m1 write; inputs change and req drops right after the latch
        m1_req   = 1'b1;
        m1_wen   = 1'b1;
        m1_addr  = 32'h1000;
        m1_wdata = 64'h1122_3344_5566_7788;
        m1_wstrb = 8'h0F;
        wait_sreq("t3", 6);
        m1_req   = 1'b0;
        m1_addr  = 32'h2000;
        m1_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        m1_wstrb = 8'hFF;
        chk("t3_addr", 64'(s_addr), 64'h1000);
        chk("t3_wen", 64'(s_wen), 64'h1);
        s_gnt = 1'b1;
        @(negedge clk);
        s_gnt = 1'b0;
        chk("t3_wait_wdata", s_wdata, 64'h1122_3344_5566_7788);
        chk("t3_wait_wstrb", 64'(s_wstrb), 64'h0F);
        chk("t3_wait_gnt", 64'({m1_gnt, m0_gnt}), 64'h2);
        slave_resp(0, 64'h0000_0000_0000_ACED, 1'b1);
        chk("t3_rvalid", 64'(m1_rvalid), 64'h1);
        drain(4);

        // Slave holds off gnt for 4 cycles: 5 stable ISSUE cycles
        m0_req   = 1'b1;
        m0_wen   = 1'b1;
        m0_addr  = 32'h3000;
        m0_wdata = 64'hA1B2_C3D4_E5F6_0718;
        m0_wstrb = 8'hF0;
        wait_sreq("t6", 6);
        m0_req  = 1'b0;
        m0_addr = 32'h3333;
        begin
            int bad = 0;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                if (!s_req || s_addr !== 32'h3000 || s_wdata !== 64'hA1B2_C3D4_E5F6_0718) bad++;
            end
            chk("t6_issue_stable", 64'(bad), 64'h0);
        end
        s_gnt = 1'b1;
        @(negedge clk);
        s_gnt = 1'b0;
        chk("t6_sreq_dropped", 64'(s_req), 64'h0);
        slave_resp(0, 64'h0000_0000_0000_6666, 1'b0);
        drain(4);

        // Timeout: gnt but never rvalid, then a stray late rvalid
        m0_req = 1'b1;
        m0_wen = 1'b0;
        wait_sreq("t4", 6);
        m0_req = 1'b0;
        s_gnt  = 1'b1;
        begin
            exp_t e;
            int early = 0;
            e.owner = 1'b0;
            e.rdata = 64'h0;
            e.err   = 1'b1;
            sbq.push_back(e);
            for (int k = 2; k <= c_TMO; k++) begin
                @(negedge clk);
                s_gnt = 1'b0;
                if (m0_rvalid || m1_rvalid) early++;
            end
            chk("t4_no_early_rvalid", 64'(early), 64'h0);
        end
        @(negedge clk);
        chk("t4_rvalid", 64'(m0_rvalid), 64'h1);
        chk("t4_err", 64'(m0_err), 64'h1);
        chk("t4_rdata_zero", m0_rdata, 64'h0);
        repeat (3) @(negedge clk);
        s_rvalid = 1'b1;
        s_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        s_rvalid = 1'b0;
        chk("t4_late_ignored", 64'({m1_rvalid, m0_rvalid, s_req}), 64'h0);
        @(negedge clk);
        chk("t4_late_ignored2", 64'({m1_rvalid, m0_rvalid, s_req}), 64'h0);
        chk("t4_rdata_held", m0_rdata, 64'h0);
        drain(2);

        // Asynchronous reset in WAIT, then tie goes to m0
        m0_req  = 1'b1;
        m0_addr = 32'h5000;
        wait_sreq("t5", 6);
        m0_req = 1'b0;
        s_gnt  = 1'b1;
        @(negedge clk);
        s_gnt = 1'b0;
        chk("t5_in_wait_gnt", 64'({m0_gnt, s_req}), 64'h2);
        #1 rst = 1'b1;
        #1 chk("t5_async_reset", 64'(any_out()), 64'h0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m0_addr = 32'h5000;
        m1_addr = 32'h6000;
        wait_sreq("t5b", 4);
        chk("t5_first_gnt_m0", 64'({m1_gnt, m0_gnt}), 64'h1);
        chk("t5_addr", 64'(s_addr), 64'h5000);
        m0_req = 1'b0;
        m1_req = 1'b0;
        slave_resp(1, 64'h0000_0000_5555_0000, 1'b0);
        drain(4);

        chk("sb_empty", 64'(sbq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
